secure_frv_masked_bitwise_pipe: RTL and testbench
=================================================

// Module: secure_frv_masked_bitwise_pipe
// PURPOSE
//  Two-share (domains A/B) masked bitwise unit for the FRV secure datapath: AND, OR, ANDN, XOR, REFRESH.
//  Nonlinear ops use the reduced-randomness DOM AND: 2 fresh N-bit masks (z0,z1) per operation.
//  Two-stage pipeline, all shares registered at accept, valid/ready on input/output.
//  Throughput 1 op/cycle; sits between the masked register-file read and the masked write-back.
// PARAMETERS
//  N   32   Data width in bits; every share and each mask word is N bits.
// PORTS
//  g_clk      in   1    Clock; all state updates on rising edge.
//  g_resetn   in   1    Asynchronous active-low reset.
//  flush      in   1    Synchronous pipeline kill (drops stage-1 and stage-2 contents).
//  in_valid   in   1    Operation request.
//  in_ready   out  1    Request accepted when in_valid & in_ready & rnd_valid.
//  op         in   3    0=AND 1=OR 2=ANDN(x&~y) 3=XOR 4=REFRESH(x); 5-7 reserved, treated as XOR.
//  ax, bx     in   N    Operand x shares, domain A / domain B (x = ax^bx).
//  ay, by     in   N    Operand y shares, domain A / domain B (y = ay^by).
//  rnd_valid  in   1    z0/z1 carry fresh, unused randomness.
//  z0, z1     in   N    Fresh masks.
//  rnd_taken  out  1    Pulses in the accept cycle; the source must advance z0/z1 next cycle.
//  out_valid  out  1    Result shares valid.
//  out_ready  in   1    Consumer takes result when out_valid & out_ready.
//  qx, qy     out  N    Result shares (result = qx^qy), domains A / B.
// BEHAVIOUR
//  Reset (async, g_resetn=0): s1_valid=0, s2_valid=0, out_valid=0, qx=qy=0, all stage registers 0.
//  adv2 = !s2_valid | out_ready.
//  in_ready = !s1_valid | adv2 (combinational; no dependence on in_valid).
//  accept = in_valid & in_ready & rnd_valid & !flush.
//  rnd_taken = accept. z0/z1 are never sampled without accept.
//  Pre-inversion at accept (domain A only): OR inverts ax and ay; ANDN inverts ay.
//  Stage 1 (on accept) registers:
//   - ax,bx,ay,by (post-inversion) and op;
//   - t1=by^z0, t0=(ax&z0)^z1, t3=ay^z0, t2=(bx&z0)^z1.
//  XOR and REFRESH reuse the t registers:
//   - XOR:     t0=ax^ay, t2=bx^by;
//   - REFRESH: t0=ax^z0, t2=bx^z0.
//  Stage 2 computes only from stage-1 registers, registered into qx/qy when s1_valid & adv2:
//   - AND/OR/ANDN: qx=((t1^ay)&ax)^t0, qy=((t3^by)&bx)^t2; OR then inverts qx.
//   - XOR/REFRESH: qx=t0, qy=t2.
//  Domain separation: no register or expression combines an A share with a B share before the
//   z0 mask is applied. The qx path never uses unmasked bx/by.
//  Valid tracking:
//   - s1_valid: set on accept; cleared when it moves to stage 2 without a new accept.
//   - s2_valid (= out_valid): set when stage 1 moves down; cleared on out_ready with no move.
//  Latency: accept at edge k -> out_valid=1 after edge k+2 when out_ready stays 1.
//  Back-pressure: with out_ready=0 both stages fill, then in_ready=0. qx/qy are held stable
//   while out_valid & !out_ready.
//  Simultaneous events in one cycle:
//   - accept, stage 1->2 move and output take proceed together; no bubble.
//  Flush: s1_valid=s2_valid=0 next edge. Flush blocks accept (in_ready may be 1, rnd_taken=0).
//   Data registers keep stale values but are never presented as valid.
//  rnd_valid=0 with in_valid=1: no accept, op is not consumed, pipeline drains normally.
//  Reset mid-operation: in-flight ops are discarded and outputs return to 0.
// TESTING
//  1 AND, N=8: ax=A5 bx=0F ay=3C by=FF z0=5A z1=33 -> qx=B2, qy=30 (x&y=82) two cycles after accept.
//  2 OR/ANDN/XOR/REFRESH on the same shares:
//     - qx^qy = EB / 28 / 69 / AA;
//     - REFRESH gives qx=FF, qy=55.
//  3 Streaming: 4 back-to-back ops with out_ready=1 -> in_ready held 1, out_valid 4 consecutive
//     cycles, in order, rnd_taken 4 pulses.
//  4 Back-pressure: out_ready=0 for 5 cycles while streaming -> in_ready drops after 2 accepts,
//     qx/qy stable, no op lost or duplicated after release.
//  5 rnd_valid=0 with in_valid=1 for 3 cycles -> no accept, rnd_taken=0; accept on rnd_valid rise.
//  6 flush with both stages full, and g_resetn asserted mid-stream -> out_valid=0 next edge
//     (immediately for reset), qx=qy=0 on reset. Random: 10k ops vs golden x op y, with
//     z0/z1 randomised.

Source files
------------

// File: rtl/secure_frv_masked_bitwise_pipe.sv
// -----------------------------------------------------------------------------
// secure_frv_masked_bitwise_pipe
//
// Purpose: two-share (domain A / domain B) masked bitwise unit for the FRV
// secure datapath. Supports AND, OR, ANDN (x & ~y), XOR and REFRESH(x).
// Nonlinear ops use a reduced-randomness DOM AND that consumes two fresh
// N-bit masks (z0, z1) per operation. Two-stage pipeline with valid/ready
// handshakes on both sides and a throughput of one op per cycle.
//
// Ports:
//   g_clk      in   clock, rising edge
//   g_resetn   in   asynchronous active-low reset
//   flush      in   synchronous kill of both pipeline stages
//   in_valid   in   operation request
//   in_ready   out  stage 1 can take a request this cycle
//   op         in   0=AND 1=OR 2=ANDN 3=XOR 4=REFRESH, 5-7 act as XOR
//   ax, bx     in   operand x shares, domain A / domain B
//   ay, by     in   operand y shares, domain A / domain B
//   rnd_valid  in   z0/z1 hold fresh randomness
//   z0, z1     in   fresh masks
//   rnd_taken  out  accept strobe; the mask source advances next cycle
//   out_valid  out  result shares valid
//   out_ready  in   consumer takes the result
//   qx, qy     out  result shares, domain A / domain B
// -----------------------------------------------------------------------------
module secure_frv_masked_bitwise_pipe #(
    parameter int N = 32
) (
    input  logic         g_clk,
    input  logic         g_resetn,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [N-1:0] ax,
    input  logic [N-1:0] bx,
    input  logic [N-1:0] ay,
    input  logic [N-1:0] by,
    input  logic         rnd_valid,
    input  logic [N-1:0] z0,
    input  logic [N-1:0] z1,
    output logic         rnd_taken,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] qx,
    output logic [N-1:0] qy
);

    localparam logic [2:0] OP_AND     = 3'd0;
    localparam logic [2:0] OP_OR      = 3'd1;
    localparam logic [2:0] OP_ANDN    = 3'd2;
    localparam logic [2:0] OP_REFRESH = 3'd4;

    logic         s1_valid_q, s1_valid_d;
    logic         s2_valid_q, s2_valid_d;
    logic [2:0]   op_q;
    logic [N-1:0] ax_q, bx_q, ay_q, by_q;
    logic [N-1:0] t0_q, t1_q, t2_q, t3_q;
    logic [N-1:0] t0_d, t1_d, t2_d, t3_d;
    logic [N-1:0] ax_m, ay_m;
    logic [N-1:0] qx_q, qy_q, qx_d, qy_d;
    logic         adv2, accept, move;
    logic         nl_in, nl_s1;

    assign adv2      = !s2_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || adv2;
    assign accept    = in_valid && in_ready && rnd_valid && !flush;
    assign move      = s1_valid_q && adv2;
    assign rnd_taken = accept;

    assign nl_in = (op == OP_AND) || (op == OP_OR) || (op == OP_ANDN);
    assign nl_s1 = (op_q == OP_AND) || (op_q == OP_OR) || (op_q == OP_ANDN);

    // De Morgan: OR becomes ~(~x & ~y), ANDN becomes x & ~y. Inverting only
    // the domain-A share inverts the shared value without touching domain B.
    always_comb begin
        ax_m = (op == OP_OR) ? ~ax : ax;
        ay_m = ((op == OP_OR) || (op == OP_ANDN)) ? ~ay : ay;
    end

    // Stage-1 terms. t1/t3 carry the cross-domain share already masked by z0,
    // so no A/B combination ever exists unmasked.
    always_comb begin
        t1_d = by ^ z0;
        t3_d = ay_m ^ z0;
        if (nl_in) begin
            t0_d = (ax_m & z0) ^ z1;
            t2_d = (bx & z0) ^ z1;
        end else if (op == OP_REFRESH) begin
            t0_d = ax_m ^ z0;
            t2_d = bx ^ z0;
        end else begin
            t0_d = ax_m ^ ay_m;
            t2_d = bx ^ by;
        end
    end

    // Stage-2 DOM recombination; the OR output inversion undoes De Morgan.
    always_comb begin
        if (nl_s1) begin
            qx_d = ((t1_q ^ ay_q) & ax_q) ^ t0_q;
            qy_d = ((t3_q ^ by_q) & bx_q) ^ t2_q;
        end else begin
            qx_d = t0_q;
            qy_d = t2_q;
        end
        if (op_q == OP_OR) begin
            qx_d = ~qx_d;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (accept) begin
                s1_valid_d = 1'b1;
            end else if (move) begin
                s1_valid_d = 1'b0;
            end
            if (move) begin
                s2_valid_d = 1'b1;
            end else if (out_ready) begin
                s2_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            op_q <= '0;
            ax_q <= '0;
            bx_q <= '0;
            ay_q <= '0;
            by_q <= '0;
            t0_q <= '0;
            t1_q <= '0;
            t2_q <= '0;
            t3_q <= '0;
        end else if (accept) begin
            op_q <= op;
            ax_q <= ax_m;
            bx_q <= bx;
            ay_q <= ay_m;
            by_q <= by;
            t0_q <= t0_d;
            t1_q <= t1_d;
            t2_q <= t2_d;
            t3_q <= t3_d;
        end
    end

    // Result shares only change on a stage move, so they hold while stalled.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            qx_q <= '0;
            qy_q <= '0;
        end else if (move) begin
            qx_q <= qx_d;
            qy_q <= qy_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign qx        = qx_q;
    assign qy        = qy_q;

endmodule

// File: tb/tb_secure_frv_masked_bitwise_pipe.sv
module tb_secure_frv_masked_bitwise_pipe;

    localparam int N = 8;

    logic         g_clk = 1'b0;
    logic         g_resetn = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         rnd_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   op = '0;
    logic [N-1:0] ax = '0, bx = '0, ay = '0, by = '0, z0 = '0, z1 = '0;
    logic         in_ready, rnd_taken, out_valid;
    logic [N-1:0] qx, qy;

    int total = 0;
    int bad = 0;

    logic [N-1:0] sb[$];
    logic         hold_pend = 1'b0;
    logic [N-1:0] hq, hy;

    logic [2:0]   c_op;
    logic [N-1:0] c_x, c_y;

    typedef struct {
        string        nm;
        logic [2:0]   op;
        logic [N-1:0] ax, bx, ay, by, z0, z1;
        logic [N-1:0] eqx, eqy;
    } vec_t;

    vec_t vecs[6];

    always #5 g_clk = ~g_clk;

    secure_frv_masked_bitwise_pipe #(.N(N)) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .ax       (ax),
        .bx       (bx),
        .ay       (ay),
        .by       (by),
        .rnd_valid(rnd_valid),
        .z0       (z0),
        .z1       (z1),
        .rnd_taken(rnd_taken),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .qx       (qx),
        .qy       (qy)
    );

    function automatic logic [N-1:0] golden(input logic [2:0] o, input logic [N-1:0] x,
                                            input logic [N-1:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x & ~y;
            3'd4:    return x;
            default: return x ^ y;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic new_op();
        c_op = 3'($urandom_range(0, 7));
        c_x  = N'($urandom);
        c_y  = N'($urandom);
    endtask

    task automatic present();
        op = c_op;
        ax = N'($urandom);
        bx = ax ^ c_x;
        ay = N'($urandom);
        by = ay ^ c_y;
        z0 = N'($urandom);
        z1 = N'($urandom);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
    endtask

    // Scoreboard and hold-stability monitor, sampled mid-cycle.
    always @(negedge g_clk) begin
        if (g_resetn) begin
            if (hold_pend && out_valid) begin
                total++;
                if (qx !== hq || qy !== hy) begin
                    bad++;
                    $display("FAIL hold: got %0h/%0h expected %0h/%0h at %0t", qx, qy, hq, hy, $time);
                end
            end
            hold_pend = out_valid && !out_ready;
            hq = qx;
            hy = qy;
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_out: got result %0h expected none at %0t", qx ^ qy, $time);
                end else begin
                    logic [N-1:0] e;
                    e = sb.pop_front();
                    if ((qx ^ qy) !== e) begin
                        bad++;
                        $display("FAIL result: got %0h expected %0h at %0t", qx ^ qy, e, $time);
                    end
                end
            end
            if (rnd_taken) sb.push_back(golden(op, ax ^ bx, ay ^ by));
        end else begin
            hold_pend = 1'b0;
        end
    end

    initial begin
        int acc;
        int cyc;
        logic [7:0] ov;
        logic [N-1:0] sx, sy;
        logic took;

        vecs[0] = '{"and",  3'd0, 8'hA5, 8'h0F, 8'h3C, 8'hFF, 8'h5A, 8'h33, 8'hB2, 8'h30};
        vecs[1] = '{"or",   3'd1, 8'hA5, 8'h0F, 8'h3C, 8'hFF, 8'h5A, 8'h33, 8'hD4, 8'h3F};
        vecs[2] = '{"andn", 3'd2, 8'hA5, 8'h0F, 8'h3C, 8'hFF, 8'h5A, 8'h33, 8'h17, 8'h3F};
        vecs[3] = '{"xor",  3'd3, 8'hA5, 8'h0F, 8'h3C, 8'hFF, 8'h5A, 8'h33, 8'h99, 8'hF0};
        vecs[4] = '{"refr", 3'd4, 8'hA5, 8'h0F, 8'h3C, 8'hFF, 8'h5A, 8'h33, 8'hFF, 8'h55};
        vecs[5] = '{"rsv7", 3'd7, 8'hA5, 8'h0F, 8'h3C, 8'hFF, 8'h5A, 8'h33, 8'h99, 8'hF0};

        repeat (2) tick();
        g_resetn = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_qx", qx, 0);
        chk("rst_qy", qy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rnd_taken", rnd_taken, 0);
        tick();

        // Directed vectors, one at a time, with latency check.
        foreach (vecs[i]) begin
            op = vecs[i].op; ax = vecs[i].ax; bx = vecs[i].bx;
            ay = vecs[i].ay; by = vecs[i].by; z0 = vecs[i].z0; z1 = vecs[i].z1;
            in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk({vecs[i].nm, "_taken"}, rnd_taken, 1);
            tick();
            in_valid = 1'b0; rnd_valid = 1'b0;
            #1;
            chk({vecs[i].nm, "_lat1"}, out_valid, 0);
            tick();
            chk({vecs[i].nm, "_valid"}, out_valid, 1);
            chk({vecs[i].nm, "_qx"}, qx, vecs[i].eqx);
            chk({vecs[i].nm, "_qy"}, qy, vecs[i].eqy);
        end
        drain();

        // Streaming: 4 back-to-back ops.
        acc = 0;
        ov = '0;
        new_op();
        for (int c = 0; c < 8; c++) begin
            in_valid  = (c < 4);
            rnd_valid = (c < 4);
            out_ready = 1'b1;
            present();
            #1;
            if (c < 4) chk("stream_in_ready", in_ready, 1);
            ov[c] = out_valid;
            took = rnd_taken;
            if (took) acc++;
            tick();
            if (took) new_op();
        end
        chk("stream_taken", acc, 4);
        chk("stream_ov", ov, 8'b0011_1100);
        drain();

        // Back-pressure: out_ready low for 5 cycles.
        acc = 0;
        out_ready = 1'b0;
        new_op();
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; rnd_valid = 1'b1;
            present();
            #1;
            chk("bp_in_ready", in_ready, (c < 2) ? 1 : 0);
            if (c == 2) begin sx = qx; sy = qy; end
            if (c > 2) begin
                chk("bp_qx_stable", qx, sx);
                chk("bp_qy_stable", qy, sy);
            end
            took = rnd_taken;
            if (took) acc++;
            tick();
            if (took) new_op();
        end
        chk("bp_accepts", acc, 2);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            present();
            #1;
            took = rnd_taken;
            tick();
            if (took) new_op();
        end
        drain();

        // No randomness: request must wait.
        new_op();
        in_valid = 1'b1; rnd_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            present();
            #1;
            chk("norand_taken", rnd_taken, 0);
            chk("norand_in_ready", in_ready, 1);
            tick();
        end
        rnd_valid = 1'b1;
        present();
        #1;
        chk("rand_rise_taken", rnd_taken, 1);
        tick();
        drain();

        // Flush with both stages full.
        out_ready = 1'b0;
        new_op();
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1; rnd_valid = 1'b1;
            present();
            #1;
            took = rnd_taken;
            tick();
            if (took) new_op();
        end
        chk("pre_flush_valid", out_valid, 1);
        flush = 1'b1; out_ready = 1'b1;
        present();
        #1;
        chk("flush_in_ready", in_ready, 1);
        chk("flush_taken", rnd_taken, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0;
        sb.delete();
        chk("flush_out_valid", out_valid, 0);
        tick();
        chk("flush_s1_killed", out_valid, 0);
        drain();

        // Reset mid-stream.
        new_op();
        in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            present();
            #1;
            took = rnd_taken;
            tick();
            if (took) new_op();
        end
        chk("pre_rst_valid", out_valid, 1);
        #2;
        g_resetn = 1'b0;
        #1;
        sb.delete();
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_qx", qx, 0);
        chk("mrst_qy", qy, 0);
        in_valid = 1'b0; rnd_valid = 1'b0;
        tick();
        g_resetn = 1'b1;
        tick();
        chk("post_rst_valid", out_valid, 0);
        drain();

        // Random traffic against the golden model.
        acc = 0;
        cyc = 0;
        new_op();
        while (acc < 10000 && cyc < 40000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            rnd_valid = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            present();
            #1;
            took = rnd_taken;
            if (took) acc++;
            tick();
            cyc++;
            if (took) new_op();
        end
        chk("rand_accepts", acc, 10000);
        in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("drain_empty", sb.size(), 0);
        tick();
        chk("final_idle", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
